// File: rtl/fractal_sync_nport_node.sv
// Barrier-sync tree node: collects N_PORTS child arrivals per (id,lvl), forwards or wakes.
// Optional error reporting is built when FRACTAL_SYNC_ERR_EN is defined.
module fractal_sync_nport_node #(
    parameter int N_PORTS  = 2,
    parameter int LVL_W    = 4,
    parameter int ID_W     = 8,
    parameter int RF_DEPTH = 4,
    parameter int NODE_LVL = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [N_PORTS-1:0]         req_valid_i,
    output logic [N_PORTS-1:0]         req_ready_o,
    input  logic [N_PORTS*LVL_W-1:0]   req_lvl_i,
    input  logic [N_PORTS*ID_W-1:0]    req_id_i,
    output logic                       up_valid_o,
    input  logic                       up_ready_i,
    output logic [LVL_W-1:0]           up_lvl_o,
    output logic [ID_W-1:0]            up_id_o,
    input  logic                       down_valid_i,
    output logic                       down_ready_o,
    input  logic [ID_W-1:0]            down_id_i,
    output logic                       rsp_valid_o,
    input  logic [N_PORTS-1:0]         rsp_ready_i,
    output logic [ID_W-1:0]            rsp_id_o,
    output logic                       err_o,
    output logic [1:0]                 err_code_o
);

    localparam int PTR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int IDX_W = (RF_DEPTH > 1) ? $clog2(RF_DEPTH) : 1;
    localparam int CNT_W = $clog2(RF_DEPTH + 1);
    localparam logic [LVL_W-1:0] NODE_LVL_V = LVL_W'(NODE_LVL);

    typedef enum logic [2:0] {FREE, COLLECT, UP_PEND, WAIT_DOWN, WAKE_PEND} ent_state_t;

    ent_state_t           ent_state_reg [RF_DEPTH];
    logic [ID_W-1:0]      ent_id_reg    [RF_DEPTH];
    logic [LVL_W-1:0]     ent_lvl_reg   [RF_DEPTH];
    logic [N_PORTS-1:0]   ent_mask_reg  [RF_DEPTH];
    logic [PTR_W-1:0]     rr_ptr_reg;
    logic [IDX_W-1:0]     upq_reg [RF_DEPTH];
    logic [IDX_W-1:0]     upq_rd_reg, upq_wr_reg;
    logic [CNT_W-1:0]     upq_cnt_reg;

    logic                 gnt_found;
    logic [PTR_W-1:0]     gnt_idx;
    logic [ID_W-1:0]      gnt_id;
    logic [LVL_W-1:0]     gnt_lvl;
    logic [N_PORTS-1:0]   gnt_bit;
    logic [RF_DEPTH-1:0]  ent_hit, ent_free, ent_wake, ent_wait_hit;
    logic [IDX_W-1:0]     hit_idx, free_idx, wake_idx, down_idx, tgt_idx, up_head;
    logic                 any_hit, lvl_low, dup, can_accept, req_fire, alloc, ent_write, up_push;
    logic                 up_fire, down_fire, down_hit, rsp_fire;
    logic [N_PORTS-1:0]   new_mask;
    ent_state_t           nxt_state;

    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] v);
        return (v == IDX_W'(RF_DEPTH - 1)) ? '0 : v + IDX_W'(1);
    endfunction

    // Round-robin: first valid port at or after the pointer, wrapping.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            int p;
            p = int'(rr_ptr_reg) + k;
            if (p >= N_PORTS) p = p - N_PORTS;
            if (!gnt_found && req_valid_i[p]) begin
                gnt_found = 1'b1;
                gnt_idx   = PTR_W'(p);
            end
        end
    end

    assign gnt_id  = req_id_i[gnt_idx*ID_W +: ID_W];
    assign gnt_lvl = req_lvl_i[gnt_idx*LVL_W +: LVL_W];
    assign gnt_bit = {{(N_PORTS-1){1'b0}}, 1'b1} << gnt_idx;

    for (genvar gi = 0; gi < RF_DEPTH; gi++) begin : g_ent
        assign ent_hit[gi]      = (ent_state_reg[gi] != FREE) && (ent_id_reg[gi] == gnt_id)
                                  && (ent_lvl_reg[gi] == gnt_lvl);
        assign ent_free[gi]     = (ent_state_reg[gi] == FREE);
        assign ent_wake[gi]     = (ent_state_reg[gi] == WAKE_PEND);
        assign ent_wait_hit[gi] = (ent_state_reg[gi] == WAIT_DOWN) && (ent_id_reg[gi] == down_id_i);
    end

    // Descending scan leaves the lowest matching index in each encoder.
    always_comb begin
        hit_idx  = '0;
        free_idx = '0;
        wake_idx = '0;
        down_idx = '0;
        for (int e = RF_DEPTH - 1; e >= 0; e--) begin
            if (ent_hit[e])      hit_idx  = IDX_W'(e);
            if (ent_free[e])     free_idx = IDX_W'(e);
            if (ent_wake[e])     wake_idx = IDX_W'(e);
            if (ent_wait_hit[e]) down_idx = IDX_W'(e);
        end
    end

    assign any_hit    = |ent_hit;
    assign lvl_low    = (gnt_lvl < NODE_LVL_V);
    assign dup        = any_hit && |(ent_mask_reg[hit_idx] & gnt_bit);
    assign can_accept = gnt_found && (lvl_low || any_hit || |ent_free);
    assign req_fire   = can_accept && !rst_i;
    assign alloc      = !any_hit;
    assign ent_write  = req_fire && !lvl_low && !dup;
    assign tgt_idx    = any_hit ? hit_idx : free_idx;
    assign new_mask   = (alloc ? '0 : ent_mask_reg[tgt_idx]) | gnt_bit;

    always_comb begin
        nxt_state = COLLECT;
        if (&new_mask) nxt_state = (gnt_lvl == NODE_LVL_V) ? WAKE_PEND : UP_PEND;
    end

    for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_rdy
        assign req_ready_o[gi] = req_fire && (gnt_idx == PTR_W'(gi));
    end

    assign up_push      = ent_write && (nxt_state == UP_PEND);
    assign up_head      = upq_reg[upq_rd_reg];
    assign up_valid_o   = (upq_cnt_reg != '0);
    assign up_id_o      = up_valid_o ? ent_id_reg[up_head] : '0;
    assign up_lvl_o     = up_valid_o ? ent_lvl_reg[up_head] : '0;
    assign up_fire      = up_valid_o && up_ready_i;

    assign rsp_valid_o  = |ent_wake;
    assign rsp_id_o     = rsp_valid_o ? ent_id_reg[wake_idx] : '0;
    assign rsp_fire     = rsp_valid_o && (&rsp_ready_i);

    assign down_ready_o = !rst_i && !rsp_valid_o;
    assign down_fire    = down_valid_i && down_ready_o;
    assign down_hit     = |ent_wait_hit;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int e = 0; e < RF_DEPTH; e++) begin
                ent_state_reg[e] <= FREE;
                ent_id_reg[e]    <= '0;
                ent_lvl_reg[e]   <= '0;
                ent_mask_reg[e]  <= '0;
                upq_reg[e]       <= '0;
            end
            rr_ptr_reg  <= '0;
            upq_rd_reg  <= '0;
            upq_wr_reg  <= '0;
            upq_cnt_reg <= '0;
        end else begin
            if (req_fire)
                rr_ptr_reg <= (gnt_idx == PTR_W'(N_PORTS - 1)) ? '0 : gnt_idx + PTR_W'(1);
            if (ent_write) begin
                ent_state_reg[tgt_idx] <= nxt_state;
                ent_mask_reg[tgt_idx]  <= new_mask;
                if (alloc) begin
                    ent_id_reg[tgt_idx]  <= gnt_id;
                    ent_lvl_reg[tgt_idx] <= gnt_lvl;
                end
            end
            // Forward queue keeps UP_PEND entries in arrival order.
            if (up_push) begin
                upq_reg[upq_wr_reg] <= tgt_idx;
                upq_wr_reg          <= idx_inc(upq_wr_reg);
            end
            if (up_fire) begin
                ent_state_reg[up_head] <= WAIT_DOWN;
                upq_rd_reg             <= idx_inc(upq_rd_reg);
            end
            if (up_push && !up_fire)      upq_cnt_reg <= upq_cnt_reg + CNT_W'(1);
            else if (!up_push && up_fire) upq_cnt_reg <= upq_cnt_reg - CNT_W'(1);
            if (down_fire && down_hit) ent_state_reg[down_idx] <= WAKE_PEND;
            if (rsp_fire) begin
                ent_state_reg[wake_idx] <= FREE;
                ent_mask_reg[wake_idx]  <= '0;
            end
        end
    end

`ifdef FRACTAL_SYNC_ERR_EN
    logic       err_reg;
    logic [1:0] err_code_reg;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_reg      <= 1'b0;
            err_code_reg <= 2'd0;
        end else if (!err_reg) begin
            if (req_fire && lvl_low) begin
                err_reg      <= 1'b1;
                err_code_reg <= 2'd1;
            end else if (req_fire && dup) begin
                err_reg      <= 1'b1;
                err_code_reg <= 2'd2;
            end else if (down_fire && !down_hit) begin
                err_reg      <= 1'b1;
                err_code_reg <= 2'd3;
            end
        end
    end

    assign err_o      = err_reg;
    assign err_code_o = err_code_reg;
`else
    assign err_o      = 1'b0;
    assign err_code_o = 2'd0;
`endif

endmodule

// File: tb/tb_fractal_sync_nport_node.sv
// Scoreboard bench for fractal_sync_nport_node (4 ports, 2 entries, node level 1).
module tb_fractal_sync_nport_node;
    localparam int NP = 4;
    localparam int LW = 4;
    localparam int IW = 8;

`ifdef FRACTAL_SYNC_ERR_EN
    localparam int EXP_ERR  = 1;
    localparam int EXP_CODE = 2;
`else
    localparam int EXP_ERR  = 0;
    localparam int EXP_CODE = 0;
`endif

    logic             clk = 1'b0;
    logic             rst_i;
    logic [NP-1:0]    req_valid_i, req_ready_o, rsp_ready_i;
    logic [NP*LW-1:0] req_lvl_i;
    logic [NP*IW-1:0] req_id_i;
    logic             up_valid_o, up_ready_i, down_valid_i, down_ready_o, rsp_valid_o, err_o;
    logic [LW-1:0]    up_lvl_o;
    logic [IW-1:0]    up_id_o, down_id_i, rsp_id_o;
    logic [1:0]       err_code_o;

    int n_cmp = 0;
    int n_bad = 0;
    int         exp_gnt[$];
    logic [7:0] exp_rsp[$];
    logic [11:0] exp_up[$];

    fractal_sync_nport_node #(
        .N_PORTS(NP), .LVL_W(LW), .ID_W(IW), .RF_DEPTH(2), .NODE_LVL(1)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_lvl_i(req_lvl_i), .req_id_i(req_id_i),
        .up_valid_o(up_valid_o), .up_ready_i(up_ready_i),
        .up_lvl_o(up_lvl_o), .up_id_o(up_id_o),
        .down_valid_i(down_valid_i), .down_ready_o(down_ready_o), .down_id_i(down_id_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_id_o(rsp_id_o),
        .err_o(err_o), .err_code_o(err_code_o)
    );

    always #5 clk = ~clk;

    function automatic void check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endfunction

    task automatic send(input int p, input logic [7:0] id, input logic [3:0] lvl, input bit pg);
        int n = 0;
        if (pg) exp_gnt.push_back(p);
        req_valid_i[p]       = 1'b1;
        req_id_i[p*IW +: IW] = id;
        req_lvl_i[p*LW +: LW] = lvl;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready_o[p] && n < 100);
        check("req_ready_port", int'(req_ready_o[p]), 1);
        @(posedge clk);
        #1 req_valid_i[p] = 1'b0;
    endtask

    task automatic down_send(input logic [7:0] id);
        int n = 0;
        down_valid_i = 1'b1;
        down_id_i    = id;
        do begin
            @(negedge clk);
            n++;
        end while (!down_ready_o && n < 100);
        check("down_ready", int'(down_ready_o), 1);
        @(posedge clk);
        #1 down_valid_i = 1'b0;
    endtask

    // Monitor: pops expected transactions whenever a handshake is presented.
    always @(negedge clk) begin
        if (!rst_i) begin
            for (int i = 0; i < NP; i++) begin
                if (req_valid_i[i] && req_ready_o[i]) begin
                    $display("req  port=%0d id=%0d lvl=%0d", i, req_id_i[i*IW +: IW], req_lvl_i[i*LW +: LW]);
                    if (exp_gnt.size() == 0) check("unexpected_grant", i, -1);
                    else check("grant_port", i, exp_gnt.pop_front());
                end
            end
            if (up_valid_o && up_ready_i) begin
                $display("up   id=%0d lvl=%0d", up_id_o, up_lvl_o);
                if (exp_up.size() == 0) check("unexpected_up", int'(up_id_o), -1);
                else check("up_lvl_id", int'({up_lvl_o, up_id_o}), int'(exp_up.pop_front()));
            end
            if (rsp_valid_o && (&rsp_ready_i)) begin
                $display("rsp  id=%0d", rsp_id_o);
                if (exp_rsp.size() == 0) check("unexpected_rsp", int'(rsp_id_o), -1);
                else check("rsp_id", int'(rsp_id_o), int'(exp_rsp.pop_front()));
            end
            if (down_valid_i && down_ready_o) $display("down id=%0d", down_id_i);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1;
        req_valid_i = '1;
        req_lvl_i = '0;
        req_id_i = '0;
        rsp_ready_i = '1;
        up_ready_i = 1'b0;
        down_valid_i = 1'b0;
        down_id_i = '0;
        repeat (2) @(negedge clk);
        check("rst_req_ready", int'(req_ready_o), 0);
        check("rst_up_valid", int'(up_valid_o), 0);
        check("rst_down_ready", int'(down_ready_o), 0);
        check("rst_rsp_valid", int'(rsp_valid_o), 0);
        check("rst_ids", int'({up_id_o, up_lvl_o, rsp_id_o}), 0);
        check("rst_err", int'({err_o, err_code_o}), 0);
        @(posedge clk);
        #1 req_valid_i = '0;
        rst_i = 1'b0;
        @(negedge clk);
        check("idle_down_ready", int'(down_ready_o), 1);

        // Round-robin with all ports continuously valid.
        foreach (exp_gnt[i]) exp_gnt.delete();
        for (int k = 0; k < 8; k++) exp_gnt.push_back(k % NP);
        exp_rsp.push_back(8'd20);
        exp_rsp.push_back(8'd21);
        @(posedge clk);
        #1;
        fork
            begin send(0, 20, 1, 0); send(0, 21, 1, 0); end
            begin send(1, 20, 1, 0); send(1, 21, 1, 0); end
            begin send(2, 20, 1, 0); send(2, 21, 1, 0); end
            begin send(3, 20, 1, 0); send(3, 21, 1, 0); end
        join
        repeat (3) @(posedge clk);
        #1;

        // Local barrier; one child holds rsp_ready low for a while.
        send(0, 5, 1, 1); send(1, 5, 1, 1); send(2, 5, 1, 1);
        rsp_ready_i = 4'b1011;
        send(3, 5, 1, 1);
        @(negedge clk);
        check("local_rsp_latency", int'(rsp_valid_o), 1);
        check("local_rsp_id", int'(rsp_id_o), 5);
        @(negedge clk);
        check("rsp_held_not_ready", int'(rsp_valid_o), 1);
        @(posedge clk);
        #1;
        exp_rsp.push_back(8'd5);
        rsp_ready_i = '1;
        @(negedge clk);
        @(negedge clk);
        check("rsp_freed", int'(rsp_valid_o), 0);
        @(posedge clk);
        #1;

        // Duplicate arrival from port 0.
        send(0, 3, 1, 1);
        send(0, 3, 1, 1);
        @(negedge clk);
        check("dup_err", int'(err_o), EXP_ERR);
        check("dup_err_code", int'(err_code_o), EXP_CODE);
        @(posedge clk);
        #1;
        exp_rsp.push_back(8'd3);
        send(1, 3, 1, 1); send(2, 3, 1, 1); send(3, 3, 1, 1);
        repeat (2) @(posedge clk);
        #1;

        // Forwarded barrier, then wake from parent.
        exp_up.push_back({4'd2, 8'd9});
        send(0, 9, 2, 1); send(1, 9, 2, 1); send(2, 9, 2, 1); send(3, 9, 2, 1);
        @(negedge clk);
        check("up_latency", int'(up_valid_o), 1);
        check("up_id", int'(up_id_o), 9);
        check("up_lvl", int'(up_lvl_o), 2);
        check("no_rsp_before_up", int'(rsp_valid_o), 0);
        @(posedge clk);
        #1 up_ready_i = 1'b1;
        @(posedge clk);
        #1 up_ready_i = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("no_rsp_before_down", int'(rsp_valid_o), 0);
            check("up_cleared", int'(up_valid_o), 0);
        end
        @(posedge clk);
        #1;
        exp_rsp.push_back(8'd9);
        down_send(9);
        repeat (3) @(posedge clk);
        #1;

        // Unmatched down wake is swallowed.
        down_send(77);
        repeat (2) begin
            @(negedge clk);
            check("unmatched_down_no_rsp", int'(rsp_valid_o), 0);
        end
        @(posedge clk);
        #1;

        // Request below node level is dropped; sticky code keeps first cause.
        send(1, 40, 0, 1);
        exp_rsp.push_back(8'd40);
        send(0, 40, 1, 1); send(1, 40, 1, 1); send(2, 40, 1, 1); send(3, 40, 1, 1);
        @(negedge clk);
        check("sticky_err", int'(err_o), EXP_ERR);
        check("sticky_err_code", int'(err_code_o), EXP_CODE);
        repeat (2) @(posedge clk);
        #1;

        // Register file full: third distinct id stalls until an entry frees.
        send(0, 10, 1, 1); send(0, 11, 1, 1); send(1, 10, 1, 1); send(2, 10, 1, 1);
        exp_gnt.push_back(3);
        exp_gnt.push_back(0);
        exp_rsp.push_back(8'd10);
        fork
            send(0, 12, 1, 0);
            begin
                repeat (3) begin
                    @(negedge clk);
                    check("full_stall_ready", int'(req_ready_o), 0);
                end
                @(posedge clk);
                #1 send(3, 10, 1, 0);
            end
        join
        exp_rsp.push_back(8'd11);
        send(1, 11, 1, 1); send(2, 11, 1, 1); send(3, 11, 1, 1);
        exp_rsp.push_back(8'd12);
        send(1, 12, 1, 1); send(2, 12, 1, 1); send(3, 12, 1, 1);
        repeat (3) @(posedge clk);
        #1;

        // Reset mid-barrier discards the pending arrival.
        send(0, 30, 1, 1);
        rst_i = 1'b1;
        req_valid_i[1] = 1'b1;
        req_id_i[IW +: IW] = 8'd30;
        req_lvl_i[LW +: LW] = 4'd1;
        @(negedge clk);
        check("midrst_req_ready", int'(req_ready_o), 0);
        check("midrst_outputs", int'({up_valid_o, down_ready_o, rsp_valid_o}), 0);
        check("midrst_err", int'({err_o, err_code_o}), 0);
        @(posedge clk);
        #1;
        req_valid_i = '0;
        rst_i = 1'b0;
        send(1, 30, 1, 1); send(2, 30, 1, 1); send(3, 30, 1, 1);
        repeat (4) begin
            @(negedge clk);
            check("no_wake_after_reset", int'(rsp_valid_o), 0);
        end
        @(posedge clk);
        #1;
        exp_rsp.push_back(8'd30);
        send(0, 30, 1, 1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("post_rst_err", int'(err_o), 0);
        check("exp_gnt_left", exp_gnt.size(), 0);
        check("exp_rsp_left", exp_rsp.size(), 0);
        check("exp_up_left", exp_up.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fractal_sync_nport_node.md
FRACTAL_SYNC_NPORT_NODE -- requirements
Module: fractal_sync_nport_node

Interface
REQ-001 Parameter N_PORTS, 2, number of child ports (2..8).
REQ-002 Parameter LVL_W, 4, barrier level width.
REQ-003 Parameter ID_W, 8, barrier id width.
REQ-004 Parameter RF_DEPTH, 4, barrier register-file entries (1..16).
REQ-005 Parameter NODE_LVL, 1, tree level of this node (1..2^LVL_W-1).
REQ-006 clk_i  in  1  single clock, rising edge.
REQ-007 rst_i  in  1  asynchronous, active-high reset.
REQ-008 req_valid_i/req_ready_o  in/out  N_PORTS  per-child barrier request handshake.
REQ-009 req_lvl_i/req_id_i  in  N_PORTS*LVL_W / N_PORTS*ID_W  per-child target level and barrier id.
REQ-010 up_valid_o/up_ready_i  out/in  1  request handshake towards parent; up_lvl_o (LVL_W), up_id_o (ID_W).
REQ-011 down_valid_i/down_ready_o  in/out  1  wake from parent; down_id_i (ID_W).
REQ-012 rsp_valid_o/rsp_ready_i  out/in  1/N_PORTS  wake broadcast to all children; rsp_id_o (ID_W).
REQ-013 err_o  out  1  sticky error flag; err_code_o  out  2  first error cause.

Function
REQ-014 Entry states: FREE, COLLECT, UP_PEND, WAIT_DOWN, WAKE_PEND; each entry holds id, lvl, N_PORTS-bit arrival mask.
REQ-015 One child request accepted per cycle, round-robin among valid ports, pointer advances past the granted port only on handshake.
REQ-016 Accepted request CAM-matches a non-FREE entry on (id,lvl); else allocates lowest-index FREE entry into COLLECT; registers update next edge.
REQ-017 No match and no FREE entry: all req_ready_o low until an entry frees; no request lost.
REQ-018 Mask all-ones with lvl==NODE_LVL: COLLECT->WAKE_PEND; with lvl>NODE_LVL: COLLECT->UP_PEND.
REQ-019 UP_PEND: up_valid_o driven with entry id/lvl (oldest UP_PEND entry first); on up handshake ->WAIT_DOWN.
REQ-020 down_ready_o high when rsp channel idle; down wake matching a WAIT_DOWN entry id -> WAKE_PEND.
REQ-021 WAKE_PEND: rsp_valid_o with rsp_id_o; fires only when all rsp_ready_i high; then entry ->FREE and mask cleared.
REQ-022 Multiple WAKE_PEND entries served lowest index first, one per cycle.
REQ-023 Latency: last arrival accepted in cycle t -> rsp_valid_o (local) or up_valid_o (forward) asserted in t+1.
REQ-024 Entry freed by wake in cycle t is allocatable in t+1, not t.
REQ-025 Request with lvl<NODE_LVL, or duplicate arrival of a port already in the mask, is accepted and dropped without state change.
REQ-026 Down wake with no matching WAIT_DOWN entry is accepted and dropped.

Reset
REQ-027 On rst_i all entries FREE, masks zero, RR pointer 0.
REQ-028 Reset values: req_ready_o 0 during reset, up_valid_o 0, down_ready_o 0, rsp_valid_o 0, ids/lvls 0, err_o 0, err_code_o 0.
REQ-029 Reset mid-barrier discards all arrivals; no wake issued for pre-reset requests.

Configuration
REQ-030 Macro FRACTAL_SYNC_ERR_EN defined: REQ-025/026 events set err_o sticky until reset; err_code_o latches first cause (1 lvl<NODE_LVL, 2 duplicate, 3 unmatched down).
REQ-031 Macro undefined: err_o and err_code_o tied 0, drops still occur silently.

Verification
REQ-032 N_PORTS=2, NODE_LVL=1: ports 0,1 send id=5 lvl=1 in cycles 0,1 -> rsp_valid_o cycle 2, rsp_id_o=5, entry freed after handshake.
REQ-033 lvl=2 id=9 from all ports -> up_valid_o up_id_o=9 up_lvl_o=2; down_id_i=9 -> rsp_id_o=9 broadcast; no rsp before down wake.
REQ-034 RF_DEPTH=2: three distinct ids, single arrivals -> third stalls (req_ready_o=0) until first completes, then accepted.
REQ-035 All ports valid continuously, N_PORTS=4 -> grants 0,1,2,3,0 in order.
REQ-036 With FRACTAL_SYNC_ERR_EN: port 0 sends id=3 twice -> err_o=1, err_code_o=2, mask unchanged; without macro err_o stays 0.
REQ-037 rst_i asserted with one arrival pending, then remaining port arrives -> no wake, entry in COLLECT with single bit.
